rs_encode_resp_framer: RTL and testbench

RS_ENCODE_RESP_FRAMER -- requirements
Module: rs_encode_resp_framer

---
 rtl/rs_encode_resp_framer.sv | 203 ++++++++++++++++++++
 tb/tb_rs_encode_resp_framer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_encode_resp_framer.sv
// Frames Reed-Solomon encoder output lines into responses: NUM_LINES data lines per block,
// then ceil(num_blocks/PARITY_PER_LINE) parity lines. Define RS_FRAMER_SKID_EN for a registered 2-entry output skid.
module rs_encode_resp_framer #(
    parameter int NUM_REQ_BLOCKS_W = 8,
    parameter int DATA_W           = 512,
    parameter int NUM_LINES        = 4,
    parameter int PARITY_PER_LINE  = 16,
    parameter int META_FIFO_DEPTH  = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        src_framer_meta_val,
    input  logic [NUM_REQ_BLOCKS_W-1:0] src_framer_meta_num_blocks,
    output logic                        framer_src_meta_rdy,
    input  logic                        stream_encoder_framer_data_val,
    input  logic [DATA_W-1:0]           stream_encoder_framer_data,
    output logic                        framer_stream_encoder_data_rdy,
    output logic                        framer_dst_resp_val,
    output logic [DATA_W-1:0]           framer_dst_resp_data,
    output logic                        framer_dst_resp_parity,
    output logic                        framer_dst_resp_last,
    input  logic                        dst_framer_resp_rdy
);

    localparam int CW     = NUM_REQ_BLOCKS_W + 1;
    localparam int PLOG   = $clog2(PARITY_PER_LINE);
    localparam int LINE_W = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
    localparam int AW     = (META_FIFO_DEPTH > 1) ? $clog2(META_FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, DATA, PARITY} state_e;

    logic [NUM_REQ_BLOCKS_W-1:0] meta_mem_q [META_FIFO_DEPTH];
    logic [AW:0]                 wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic                        fifo_empty, fifo_full, meta_push, meta_pop;
    logic [NUM_REQ_BLOCKS_W-1:0] head_nb;
    logic [CW-1:0]               par_sum;

    state_e                      state_q, state_d;
    logic [NUM_REQ_BLOCKS_W-1:0] num_blocks_q, num_blocks_d;
    logic [NUM_REQ_BLOCKS_W-1:0] blk_cnt_q, blk_cnt_d;
    logic [LINE_W-1:0]           line_cnt_q, line_cnt_d;
    logic [CW-1:0]               par_cnt_q, par_cnt_d;
    logic [CW-1:0]               par_total_q, par_total_d;
    logic                        active_q, active_d;
    logic                        parity_q, parity_d;
    logic                        last_q, last_d;
    logic                        line_xfer;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign framer_src_meta_rdy = !fifo_full && !rst;
    assign meta_push  = src_framer_meta_val && framer_src_meta_rdy;
    assign head_nb    = meta_mem_q[rd_ptr_q[AW-1:0]];
    assign par_sum    = CW'(head_nb) + CW'(PARITY_PER_LINE - 1);
    assign line_xfer  = stream_encoder_framer_data_val && framer_stream_encoder_data_rdy;

`ifdef RS_FRAMER_SKID_EN
    logic [DATA_W-1:0] skid_data_q [2];
    logic [1:0]        skid_par_q, skid_last_q;
    logic              skid_wr_q, skid_wr_d, skid_rd_q, skid_rd_d;
    logic [1:0]        skid_cnt_q, skid_cnt_d;
    logic              skid_pop;

    // Input side only looks at skid occupancy (and whether a frame is open), never at dst ready.
    assign framer_stream_encoder_data_rdy = active_q && !rst && (skid_cnt_q != 2'd2);
    assign framer_dst_resp_val    = (skid_cnt_q != 2'd0) && !rst;
    assign framer_dst_resp_data   = skid_data_q[skid_rd_q];
    assign framer_dst_resp_parity = skid_par_q[skid_rd_q] && framer_dst_resp_val;
    assign framer_dst_resp_last   = skid_last_q[skid_rd_q] && framer_dst_resp_val;
    assign skid_pop = framer_dst_resp_val && dst_framer_resp_rdy;

    always_comb begin
        skid_wr_d  = skid_wr_q ^ line_xfer;
        skid_rd_d  = skid_rd_q ^ skid_pop;
        skid_cnt_d = skid_cnt_q + {1'b0, line_xfer} - {1'b0, skid_pop};
    end

    always_ff @(posedge clk) begin
        if (line_xfer) begin
            skid_data_q[skid_wr_q] <= stream_encoder_framer_data;
            skid_par_q[skid_wr_q]  <= parity_q;
            skid_last_q[skid_wr_q] <= last_q;
        end
    end
`else
    assign framer_stream_encoder_data_rdy = active_q && !rst && dst_framer_resp_rdy;
    assign framer_dst_resp_val    = active_q && !rst && stream_encoder_framer_data_val;
    assign framer_dst_resp_data   = stream_encoder_framer_data;
    assign framer_dst_resp_parity = parity_q && !rst;
    assign framer_dst_resp_last   = last_q && !rst;
`endif

    always_ff @(posedge clk) begin
        if (meta_push) begin
            meta_mem_q[wr_ptr_q[AW-1:0]] <= src_framer_meta_num_blocks;
        end
    end

    always_comb begin
        state_d      = state_q;
        num_blocks_d = num_blocks_q;
        blk_cnt_d    = blk_cnt_q;
        line_cnt_d   = line_cnt_q;
        par_cnt_d    = par_cnt_q;
        par_total_d  = par_total_q;
        active_d     = active_q;
        parity_d     = parity_q;
        last_d       = last_q;
        meta_pop     = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Zero-block requests are popped and dropped without leaving IDLE.
                if (!fifo_empty) begin
                    meta_pop = 1'b1;
                    if (head_nb != '0) begin
                        num_blocks_d = head_nb;
                        blk_cnt_d    = '0;
                        line_cnt_d   = '0;
                        par_cnt_d    = '0;
                        par_total_d  = par_sum >> PLOG;
                        active_d     = 1'b1;
                        state_d      = DATA;
                    end
                end
            end
            DATA: begin
                if (line_xfer) begin
                    if (line_cnt_q == LINE_W'(NUM_LINES - 1)) begin
                        line_cnt_d = '0;
                        if (blk_cnt_q == num_blocks_q - NUM_REQ_BLOCKS_W'(1)) begin
                            blk_cnt_d = '0;
                            parity_d  = 1'b1;
                            last_d    = (par_total_q == CW'(1));
                            state_d   = PARITY;
                        end else begin
                            blk_cnt_d = blk_cnt_q + NUM_REQ_BLOCKS_W'(1);
                        end
                    end else begin
                        line_cnt_d = line_cnt_q + LINE_W'(1);
                    end
                end
            end
            PARITY: begin
                if (line_xfer) begin
                    if (last_q) begin
                        par_cnt_d = '0;
                        active_d  = 1'b0;
                        parity_d  = 1'b0;
                        last_d    = 1'b0;
                        state_d   = IDLE;
                    end else begin
                        par_cnt_d = par_cnt_q + CW'(1);
                        last_d    = (par_cnt_q + CW'(2) == par_total_q);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, meta_push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, meta_pop};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            num_blocks_q <= '0;
            blk_cnt_q    <= '0;
            line_cnt_q   <= '0;
            par_cnt_q    <= '0;
            par_total_q  <= '0;
            active_q     <= 1'b0;
            parity_q     <= 1'b0;
            last_q       <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
`ifdef RS_FRAMER_SKID_EN
            skid_wr_q    <= 1'b0;
            skid_rd_q    <= 1'b0;
            skid_cnt_q   <= 2'd0;
`endif
        end else begin
            state_q      <= state_d;
            num_blocks_q <= num_blocks_d;
            blk_cnt_q    <= blk_cnt_d;
            line_cnt_q   <= line_cnt_d;
            par_cnt_q    <= par_cnt_d;
            par_total_q  <= par_total_d;
            active_q     <= active_d;
            parity_q     <= parity_d;
            last_q       <= last_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
`ifdef RS_FRAMER_SKID_EN
            skid_wr_q    <= skid_wr_d;
            skid_rd_q    <= skid_rd_d;
            skid_cnt_q   <= skid_cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_rs_encode_resp_framer.sv
// Self-checking bench for rs_encode_resp_framer (default pass-through build); each accepted request
// is expanded into its expected line sequence of {parity,last} flags and compared against the output.
module tb_rs_encode_resp_framer;

    localparam int NB_W      = 8;
    localparam int DATA_W    = 512;
    localparam int NUM_LINES = 4;
    localparam int PPL       = 16;
    localparam int DEPTH     = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              src_framer_meta_val = 1'b0;
    logic [NB_W-1:0]   src_framer_meta_num_blocks = '0;
    logic              framer_src_meta_rdy;
    logic              stream_encoder_framer_data_val = 1'b0;
    logic [DATA_W-1:0] stream_encoder_framer_data = '0;
    logic              framer_stream_encoder_data_rdy;
    logic              framer_dst_resp_val;
    logic [DATA_W-1:0] framer_dst_resp_data;
    logic              framer_dst_resp_parity;
    logic              framer_dst_resp_last;
    logic              dst_framer_resp_rdy = 1'b0;

    int vectors    = 0;
    int miscompares = 0;
    int xfer_cnt   = 0;
    bit [1:0] exp_q[$];
    bit src_en = 1'b0, src_rand = 1'b0, sink_rand = 1'b0;
    bit line_taken = 1'b0;
    bit prev_stalled = 1'b0;
    logic [DATA_W-1:0] prev_data = '0;

    rs_encode_resp_framer #(
        .NUM_REQ_BLOCKS_W(NB_W), .DATA_W(DATA_W), .NUM_LINES(NUM_LINES),
        .PARITY_PER_LINE(PPL), .META_FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .src_framer_meta_val(src_framer_meta_val),
        .src_framer_meta_num_blocks(src_framer_meta_num_blocks),
        .framer_src_meta_rdy(framer_src_meta_rdy),
        .stream_encoder_framer_data_val(stream_encoder_framer_data_val),
        .stream_encoder_framer_data(stream_encoder_framer_data),
        .framer_stream_encoder_data_rdy(framer_stream_encoder_data_rdy),
        .framer_dst_resp_val(framer_dst_resp_val),
        .framer_dst_resp_data(framer_dst_resp_data),
        .framer_dst_resp_parity(framer_dst_resp_parity),
        .framer_dst_resp_last(framer_dst_resp_last),
        .dst_framer_resp_rdy(dst_framer_resp_rdy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Number of lines a request produces: NUM_LINES per block plus one parity line per PPL blocks.
    function automatic int linesFor(input int nb);
        return nb * NUM_LINES + (nb + PPL - 1) / PPL;
    endfunction

    // Offer one request; once it is accepted, append its expected line sequence to the model.
    task automatic applyStimulus(input int nb);
        int budget;
        int np;
        bit done;
        budget = 2000;
        done = 1'b0;
        src_framer_meta_val = 1'b1;
        src_framer_meta_num_blocks = NB_W'(nb);
        while (!done) begin
            @(negedge clk);
            if (framer_src_meta_rdy) begin
                np = (nb + PPL - 1) / PPL;
                for (int i = 0; i < nb * NUM_LINES; i++) exp_q.push_back(2'b00);
                for (int i = 0; i < np; i++) exp_q.push_back({1'b1, (i == np - 1)});
                done = 1'b1;
            end else begin
                budget--;
                if (budget == 0) begin
                    checkOutput("meta_accept_timeout", 0, 1);
                    done = 1'b1;
                end
            end
            @(posedge clk); #1;
        end
        src_framer_meta_val = 1'b0;
    endtask

    task automatic waitDrain(input string tag, input int exp_lines);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 5000) begin
            @(posedge clk);
            n++;
        end
        checkOutput({tag, "_drained"}, exp_q.size(), 0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput({tag, "_lines"}, xfer_cnt, exp_lines);
        checkOutput({tag, "_meta_rdy"}, framer_src_meta_rdy, 1);
        xfer_cnt = 0;
    endtask

    // Output monitor: every visible line is compared against the head of the expected sequence.
    always @(negedge clk) begin
        line_taken = stream_encoder_framer_data_val && framer_stream_encoder_data_rdy;
        if (rst) begin
            prev_stalled = 1'b0;
        end else begin
            if (exp_q.size() == 0) begin
                checkOutput("idle_resp_val", framer_dst_resp_val, 0);
                checkOutput("idle_data_rdy", framer_stream_encoder_data_rdy, 0);
            end else if (framer_dst_resp_val) begin
                checkOutput("parity_flag", framer_dst_resp_parity, exp_q[0][1]);
                checkOutput("last_flag", framer_dst_resp_last, exp_q[0][0]);
                checkOutput("data_pass", framer_dst_resp_data, stream_encoder_framer_data);
                checkOutput("rdy_pass", framer_stream_encoder_data_rdy, dst_framer_resp_rdy);
                if (prev_stalled) checkOutput("stall_hold", framer_dst_resp_data, prev_data);
                if (dst_framer_resp_rdy) begin
                    void'(exp_q.pop_front());
                    xfer_cnt++;
                end
            end
            prev_stalled = framer_dst_resp_val && !dst_framer_resp_rdy;
            prev_data = framer_dst_resp_data;
        end
    end

    // Encoder source holds each line until accepted; downstream ready optionally toggles randomly.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (line_taken || !stream_encoder_framer_data_val || !src_en) begin
                stream_encoder_framer_data_val = src_en && (!src_rand || ($urandom % 4 != 0));
                for (int i = 0; i < DATA_W / 32; i++) stream_encoder_framer_data[i*32 +: 32] = $urandom;
            end
            dst_framer_resp_rdy = !sink_rand || ($urandom % 3 != 0);
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int nb;
        int total;
        int n;

        repeat (3) begin
            @(negedge clk);
            checkOutput("rst_meta_rdy", framer_src_meta_rdy, 0);
            checkOutput("rst_resp_val", framer_dst_resp_val, 0);
            checkOutput("rst_data_rdy", framer_stream_encoder_data_rdy, 0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_meta_rdy", framer_src_meta_rdy, 1);
        checkOutput("post_rst_parity", framer_dst_resp_parity, 0);
        checkOutput("post_rst_last", framer_dst_resp_last, 0);
        @(posedge clk); #1;
        src_en = 1'b1;

        $display("[TB] single request, 3 blocks");
        applyStimulus(3);
        waitDrain("nb3", 13);

        $display("[TB] single request, 17 blocks");
        applyStimulus(17);
        waitDrain("nb17", 70);

        $display("[TB] zero-block request followed by 1 block");
        applyStimulus(0);
        applyStimulus(1);
        waitDrain("nb0_nb1", 5);

        $display("[TB] metadata FIFO fill with encoder idle");
        src_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        applyStimulus(1);
        applyStimulus(2);
        applyStimulus(17);
        applyStimulus(3);
        applyStimulus(1);
        @(negedge clk);
        checkOutput("fifo_full_meta_rdy", framer_src_meta_rdy, 0);
        @(posedge clk); #1;
        src_en = 1'b1;
        waitDrain("fifo_order", linesFor(1) + linesFor(2) + linesFor(17) + linesFor(3) + linesFor(1));

        $display("[TB] random stalls, 2 blocks");
        src_rand = 1'b1;
        sink_rand = 1'b1;
        applyStimulus(2);
        waitDrain("stall_nb2", 9);

        $display("[TB] reset mid-request");
        src_rand = 1'b0;
        sink_rand = 1'b0;
        applyStimulus(4);
        n = 0;
        while (xfer_cnt < 5 && n < 500) begin
            @(posedge clk);
            n++;
        end
        #1;
        checkOutput("pre_rst_lines", xfer_cnt, 5);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        checkOutput("midrst_meta_rdy", framer_src_meta_rdy, 0);
        checkOutput("midrst_resp_val", framer_dst_resp_val, 0);
        checkOutput("midrst_data_rdy", framer_stream_encoder_data_rdy, 0);
        checkOutput("midrst_parity", framer_dst_resp_parity, 0);
        checkOutput("midrst_last", framer_dst_resp_last, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        xfer_cnt = 0;
        @(negedge clk);
        checkOutput("after_rst_meta_rdy", framer_src_meta_rdy, 1);
        checkOutput("after_rst_resp_val", framer_dst_resp_val, 0);
        checkOutput("after_rst_data_rdy", framer_stream_encoder_data_rdy, 0);
        checkOutput("after_rst_parity", framer_dst_resp_parity, 0);
        checkOutput("after_rst_last", framer_dst_resp_last, 0);
        @(posedge clk); #1;
        applyStimulus(1);
        waitDrain("post_rst_nb1", 5);

        $display("[TB] random requests with random stalls");
        src_rand = 1'b1;
        sink_rand = 1'b1;
        total = 0;
        for (int k = 0; k < 6; k++) begin
            nb = $urandom % 41;
            total += linesFor(nb);
            applyStimulus(nb);
        end
        waitDrain("random", total);

        $display("[TB] == %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
